exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_pkg.sv | 37 +++
 rtl/cp0_regs.sv | 87 ++++++++
 rtl/exc_ctrl.sv | 82 ++++++++
 tb/tb_exc_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared CP0 definitions for the exception controller: register addresses,
// field positions inside SR/Cause, and the exception codes the pipeline raises.
package exc_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h2021_0801;

  // EPC always holds a word address, so the low two bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] value);
    return {value[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// CP0 register storage (SR, Cause, EPC) plus the mfc0 read mux.
// Exception entry takes precedence over any mtc0 write in the same cycle.
module cp0_regs
  import exc_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wd,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic        bd_in,
  input  logic [31:0] epc_in,
  input  logic        eret_take,
  output logic [31:0] rdata,
  output logic [5:0]  im,
  output logic        exl,
  output logic        ie,
  output logic [31:0] epc_q
);

  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code_q;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ip         <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ip <= hw_int;
      if (exc_take) begin
        exl        <= 1'b1;
        bd         <= bd_in;
        exc_code_q <= exc_code;
        epc_q      <= epc_in;
      end else begin
        if (we && addr == ADDR_SR) begin
          im  <= wd[SR_IM_HI:SR_IM_LO];
          exl <= wd[SR_EXL_BIT];
          ie  <= wd[SR_IE_BIT];
        end
        if (we && addr == ADDR_EPC) begin
          epc_q <= word_align(wd);
        end
        // eret is applied after any SR write so leaving the handler always clears EXL.
        if (eret_take) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word                           = '0;
    sr_word[SR_IM_HI:SR_IM_LO]        = im;
    sr_word[SR_EXL_BIT]               = exl;
    sr_word[SR_IE_BIT]                = ie;
    cause_word                        = '0;
    cause_word[CAUSE_BD_BIT]          = bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc_q;
      ADDR_PRID:  rdata = PRID_VAL;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: decides when the M-stage instruction traps,
// which cause to record, and drives the fetch-unit redirect (exc/eret/epc).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] PRID_VAL   = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        valid_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rdata,
  output logic        exc,
  output logic        eret,
  output logic [31:0] epc,
  output logic [31:0] handler_pc
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [31:0] epc_q;
  logic        int_req;
  logic        internal_exc;
  logic [4:0]  exc_code_sel;
  logic [31:0] epc_next;

  // Interrupts only fire on a real instruction so EPC always points at something restartable.
  assign int_req      = (|(hw_int & im)) & ie & ~exl & valid_m;
  assign internal_exc = valid_m & (exc_code_m != 5'd0);

  // Outputs are gated by reset so nothing redirects fetch while the block is held in reset.
  assign exc  = reset & ~exl & (int_req | internal_exc);
  assign eret = reset & eret_m & ~exc;

  assign exc_code_sel = int_req ? EXC_INT : exc_code_m;
  assign epc_next     = bd_m ? (pc_m - 32'd4) : pc_m;

  // Forward an in-flight EPC write so an eret in the same cycle returns to the new address.
  always_comb begin
    epc = '0;
    if (reset) begin
      if (we && addr == ADDR_EPC) begin
        epc = word_align(wd);
      end else begin
        epc = epc_q;
      end
    end
  end

  assign handler_pc = HANDLER_PC;

  cp0_regs #(
    .PRID_VAL(PRID_VAL)
  ) u_cp0_regs (
    .clk       (clk),
    .reset     (reset),
    .hw_int    (hw_int),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .exc_take  (exc),
    .exc_code  (exc_code_sel),
    .bd_in     (bd_m),
    .epc_in    (epc_next),
    .eret_take (eret),
    .rdata     (rdata),
    .im        (im),
    .exl       (exl),
    .ie        (ie),
    .epc_q     (epc_q)
  );

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic
// compared against a word-level model of the CP0 registers.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        valid_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] handler_pc;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] PRID = 32'h2021_0801;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  // Model state held as whole architectural words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .valid_m    (valid_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .eret_m     (eret_m),
    .hw_int     (hw_int),
    .we         (we),
    .addr       (addr),
    .wd         (wd),
    .rdata      (rdata),
    .exc        (exc),
    .eret       (eret),
    .epc        (epc),
    .handler_pc (handler_pc)
  );

  function automatic logic model_int();
    return valid_m && m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic model_exc();
    return reset && !m_sr[1] && (model_int() || (valid_m && exc_code_m != 5'd0));
  endfunction

  function automatic logic model_eret();
    return reset && eret_m && !model_exc();
  endfunction

  function automatic logic [31:0] model_epc();
    if (!reset) return 32'd0;
    if (we && addr == 5'd14) return wd & 32'hFFFF_FFFC;
    return m_epc;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  task automatic model_step();
    logic take;
    logic intr;
    take = model_exc();
    intr = model_int();
    if (take) begin
      m_sr[1]    = 1'b1;
      m_cause[31] = bd_m;
      m_cause[6:2] = intr ? 5'd0 : exc_code_m;
      m_epc      = bd_m ? pc_m - 32'd4 : pc_m;
    end else begin
      if (we && addr == 5'd12) m_sr = wd & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
      if (eret_m) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = hw_int;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    pc_m = 32'd0; valid_m = 1'b0; bd_m = 1'b0; exc_code_m = 5'd0;
    eret_m = 1'b0; hw_int = 6'd0; we = 1'b0; addr = 5'd0; wd = 32'd0;
  endtask

  task automatic write_sr(input logic [31:0] value);
    set_idle();
    we = 1'b1; addr = 5'd12; wd = value;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    model_clear();
    valid_m = 1'b1; exc_code_m = 5'd12; hw_int = 6'h3F; eret_m = 1'b1;
    #1;
    n_checks++;
    if (exc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_exc: got %b expected 0", exc); end
    n_checks++;
    if (eret !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_eret: got %b expected 0", eret); end
    n_checks++;
    if (epc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_epc: got %h expected 0", epc); end
    n_checks++;
    if (handler_pc !== HPC) begin n_fail++; $display("[TB] FAIL handler_pc: got %h expected %h", handler_pc, HPC); end
    for (int a = 12; a <= 15; a++) begin
      addr = 5'(a);
      #1;
      n_checks++;
      if (rdata !== model_rdata(addr)) begin
        n_fail++; $display("[TB] FAIL reset_rdata[%0d]: got %h expected %h", a, rdata, model_rdata(addr));
      end
    end
    set_idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_interrupt();
    write_sr(32'h0000_0401);
    hw_int = 6'b000001; valid_m = 1'b1; pc_m = 32'h3010;
    #1;
    n_checks++;
    if (exc !== 1'b1) begin n_fail++; $display("[TB] FAIL int_exc: got %b expected 1", exc); end
    tick();
    set_idle();
    hw_int = 6'b000001;
    addr = 5'd14;
    #1;
    n_checks++;
    if (rdata !== 32'h3010) begin n_fail++; $display("[TB] FAIL int_epc: got %h expected 00003010", rdata); end
    addr = 5'd12;
    #1;
    n_checks++;
    if (rdata !== 32'h0000_0403) begin n_fail++; $display("[TB] FAIL int_sr_exl: got %h expected 00000403", rdata); end
    addr = 5'd13;
    #1;
    n_checks++;
    if (rdata[6:2] !== 5'd0 || rdata !== model_rdata(5'd13)) begin
      n_fail++; $display("[TB] FAIL int_cause: got %h expected %h", rdata, model_rdata(5'd13));
    end
    eret_m = 1'b1; valid_m = 1'b1;
    #1;
    n_checks++;
    if (eret !== 1'b1 || exc !== 1'b0 || epc !== 32'h3010) begin
      n_fail++; $display("[TB] FAIL int_eret: got eret=%b exc=%b epc=%h expected 1 0 00003010", eret, exc, epc);
    end
    tick();
    set_idle();
  endtask

  task automatic test_delay_slot();
    exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h3024; valid_m = 1'b1;
    #1;
    n_checks++;
    if (exc !== 1'b1) begin n_fail++; $display("[TB] FAIL bd_exc: got %b expected 1", exc); end
    tick();
    set_idle();
    addr = 5'd14;
    #1;
    n_checks++;
    if (rdata !== 32'h3020) begin n_fail++; $display("[TB] FAIL bd_epc: got %h expected 00003020", rdata); end
    addr = 5'd13;
    #1;
    n_checks++;
    if (rdata !== 32'h8000_0030) begin n_fail++; $display("[TB] FAIL bd_cause: got %h expected 80000030", rdata); end
  endtask

  task automatic test_nested();
    set_idle();
    exc_code_m = 5'd10; hw_int = 6'b000001; valid_m = 1'b1; pc_m = 32'h5000;
    #1;
    n_checks++;
    if (exc !== 1'b0) begin n_fail++; $display("[TB] FAIL nest_exc: got %b expected 0", exc); end
    tick();
    set_idle();
    eret_m = 1'b1; valid_m = 1'b1;
    #1;
    n_checks++;
    if (eret !== 1'b1 || epc !== 32'h3020) begin
      n_fail++; $display("[TB] FAIL nest_eret: got eret=%b epc=%h expected 1 00003020", eret, epc);
    end
    tick();
    set_idle();
    addr = 5'd12;
    #1;
    n_checks++;
    if (rdata !== 32'h0000_0401) begin n_fail++; $display("[TB] FAIL nest_sr: got %h expected 00000401", rdata); end
  endtask

  task automatic test_forward();
    set_idle();
    we = 1'b1; addr = 5'd14; wd = 32'h3047; eret_m = 1'b1; valid_m = 1'b1;
    #1;
    n_checks++;
    if (epc !== 32'h3044 || eret !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fwd_epc: got epc=%h eret=%b expected 00003044 1", epc, eret);
    end
    tick();
    set_idle();
    addr = 5'd14;
    #1;
    n_checks++;
    if (rdata !== 32'h3044) begin n_fail++; $display("[TB] FAIL fwd_stored: got %h expected 00003044", rdata); end
  endtask

  task automatic test_coincide();
    set_idle();
    exc_code_m = 5'd4; valid_m = 1'b1; pc_m = 32'h4000; we = 1'b1; addr = 5'd14; wd = 32'h5000;
    #1;
    n_checks++;
    if (exc !== 1'b1) begin n_fail++; $display("[TB] FAIL coin_exc: got %b expected 1", exc); end
    tick();
    set_idle();
    addr = 5'd14;
    #1;
    n_checks++;
    if (rdata !== 32'h4000) begin n_fail++; $display("[TB] FAIL coin_epc: got %h expected 00004000", rdata); end
    addr = 5'd13;
    #1;
    n_checks++;
    if (rdata !== 32'h0000_0010) begin n_fail++; $display("[TB] FAIL coin_cause: got %h expected 00000010", rdata); end
    eret_m = 1'b1;
    tick();
    set_idle();
    // Writes to Cause, PRId and unimplemented addresses must not change anything.
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; wd = 32'hFFFF_FFFF;
      addr = (i == 0) ? 5'd13 : (i == 1) ? 5'd15 : 5'd3;
      tick();
    end
    set_idle();
    for (int a = 12; a <= 15; a++) begin
      addr = 5'(a);
      #1;
      n_checks++;
      if (rdata !== model_rdata(addr)) begin
        n_fail++; $display("[TB] FAIL ignore_wr[%0d]: got %h expected %h", a, rdata, model_rdata(addr));
      end
    end
  endtask

  task automatic test_valid_gate();
    write_sr(32'h0000_0401);
    hw_int = 6'b000001; pc_m = 32'h6000;
    for (int i = 0; i < 3; i++) begin
      valid_m = 1'b0;
      #1;
      n_checks++;
      if (exc !== 1'b0) begin n_fail++; $display("[TB] FAIL gate_exc[%0d]: got %b expected 0", i, exc); end
      tick();
    end
    valid_m = 1'b1;
    #1;
    n_checks++;
    if (exc !== 1'b1) begin n_fail++; $display("[TB] FAIL gate_release: got %b expected 1", exc); end
    tick();
    valid_m = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    for (int a = 12; a <= 14; a++) begin
      addr = 5'(a);
      #1;
      n_checks++;
      if (rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_reset[%0d]: got %h expected 0", a, rdata); end
    end
    @(negedge clk);
    reset = 1'b1;
    valid_m = 1'b1;
    #1;
    n_checks++;
    if (exc !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_exc: got %b expected 0", exc); end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    logic [4:0] codes [8];
    codes[0] = 5'd0; codes[1] = 5'd0; codes[2] = 5'd0; codes[3] = 5'd4;
    codes[4] = 5'd5; codes[5] = 5'd10; codes[6] = 5'd12; codes[7] = 5'd0;
    for (int i = 0; i < 400; i++) begin
      valid_m    = ($urandom_range(0, 3) != 0);
      exc_code_m = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 7)];
      bd_m       = 1'($urandom);
      pc_m       = {$urandom, 2'b00} ^ 32'd0;
      pc_m[1:0]  = 2'b00;
      eret_m     = ($urandom_range(0, 2) == 0);
      hw_int     = 6'($urandom);
      we         = ($urandom_range(0, 2) == 0);
      addr       = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      wd         = $urandom;
      #1;
      n_checks++;
      if (exc !== model_exc()) begin n_fail++; $display("[TB] FAIL rnd_exc[%0d]: got %b expected %b", i, exc, model_exc()); end
      n_checks++;
      if (eret !== model_eret()) begin n_fail++; $display("[TB] FAIL rnd_eret[%0d]: got %b expected %b", i, eret, model_eret()); end
      n_checks++;
      if (epc !== model_epc()) begin n_fail++; $display("[TB] FAIL rnd_epc[%0d]: got %h expected %h", i, epc, model_epc()); end
      n_checks++;
      if (rdata !== model_rdata(addr)) begin
        n_fail++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", i, rdata, model_rdata(addr));
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_delay_slot();
    test_nested();
    test_forward();
    test_coincide();
    test_valid_gate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
